// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming K_DIM x K_DIM convolution with N_KERNELS filters
// evaluated in parallel. Pixels arrive in raster order over ready/valid; the
// previous K_DIM-1 rows sit in line buffers and the left K_DIM-1 columns of
// the current window in a small shift register. The newest window column is
// assembled combinationally on the accept cycle, so the MAC sees the complete
// window in the same cycle and the result lands in a single output register.
module conv2d_stream #(
    parameter int PIX_WIDTH = 8,
    parameter int W_WIDTH   = 12,
    parameter int OUT_WIDTH = 8,
    parameter int IM_DIM    = 28,
    parameter int K_DIM     = 3,
    parameter int N_KERNELS = 4,
    parameter int STRIDE    = 1,
    parameter int SHIFT     = 0
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    clear_i,
    input  logic [N_KERNELS*K_DIM*K_DIM*W_WIDTH-1:0] weights_i,
    input  logic                                    relu_i,
    input  logic [PIX_WIDTH-1:0]                    pix_i,
    input  logic                                    pix_valid_i,
    output logic                                    pix_ready_o,
    output logic [N_KERNELS*OUT_WIDTH-1:0]          out_data_o,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic                                    busy_o,
    output logic                                    all_read_o,
    output logic                                    frame_done_o
);

    localparam int KK    = K_DIM * K_DIM;
    localparam int WB    = N_KERNELS * KK * W_WIDTH;
    localparam int ACC_W = PIX_WIDTH + W_WIDTH + $clog2(KK) + 1;
    localparam int CNT_W = $clog2(IM_DIM);

    localparam logic [CNT_W-1:0] POS_LAST  = CNT_W'(IM_DIM - 1);
    localparam logic [CNT_W-1:0] POS_FIRST = CNT_W'(K_DIM - 1);
    // Parity of K_DIM-1: with STRIDE 2, a window is taken when the offset
    // from the first window position is even, i.e. when the parities match.
    localparam logic             K1_LSB    = 1'((K_DIM - 1) % 2);

    localparam logic signed [ACC_W-1:0]   SAT_MAX = ACC_W'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [ACC_W-1:0]   SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_WIDTH-1:0]      OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]      OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     row_q, row_d;
    logic [CNT_W-1:0]     col_q, col_d;
    logic [WB-1:0]        weights_q;
    logic                 relu_q;
    logic                 out_valid_q;
    logic [N_KERNELS*OUT_WIDTH-1:0] out_data_q;

    logic [PIX_WIDTH-1:0] lb_q  [K_DIM-1][IM_DIM];
    logic [PIX_WIDTH-1:0] win_q [K_DIM][K_DIM-1];
    logic [PIX_WIDTH-1:0] tap   [K_DIM][K_DIM];

    logic                 accept;
    logic                 out_hs;
    logic                 last_pix;
    logic                 stride_ok;
    logic                 win_ok;
    logic                 fire;
    logic                 frame_done;
    logic [N_KERNELS*OUT_WIDTH-1:0] mac_out;

    // A stalled output blocks new pixels: accepting one could overwrite it.
    assign pix_ready_o  = !rst_i && (!out_valid_q || out_ready_i);
    assign accept       = pix_valid_i && pix_ready_o && !clear_i;
    assign out_hs       = out_valid_q && out_ready_i;
    assign last_pix     = (row_q == POS_LAST) && (col_q == POS_LAST);
    assign stride_ok    = (STRIDE == 1) || ((row_q[0] == K1_LSB) && (col_q[0] == K1_LSB));
    assign win_ok       = (row_q >= POS_FIRST) && (col_q >= POS_FIRST) && stride_ok;
    assign fire         = accept && win_ok;

    assign busy_o       = (state_q != IDLE);
    assign all_read_o   = accept && last_pix;
    assign frame_done_o = frame_done;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;

    // Frame state and raster position registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next state, raster advance and frame completion; clear overrides all
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE:  if (accept) state_d = RUN;
            RUN:   if (accept && last_pix) state_d = DRAIN;
            DRAIN: begin
                // Nothing more can be produced after the last pixel, so the
                // output register is the only thing left to wait for. A pixel
                // accepted here already belongs to the next frame.
                if (!out_valid_q || out_ready_i) begin
                    frame_done = 1'b1;
                    state_d    = accept ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (col_q == POS_LAST) begin
                col_d = '0;
                row_d = (row_q == POS_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (clear_i) begin
            state_d    = IDLE;
            row_d      = '0;
            col_d      = '0;
            frame_done = 1'b0;
        end
    end

    // Current window: stored columns plus the column completed by pix_i
    always_comb begin
        for (int r = 0; r < K_DIM; r++)
            for (int c = 0; c < K_DIM - 1; c++)
                tap[r][c] = win_q[r][c];
        for (int r = 0; r < K_DIM - 1; r++)
            tap[r][K_DIM-1] = lb_q[r][col_q];
        tap[K_DIM-1][K_DIM-1] = pix_i;
    end

    // Line buffers and window shift register advance on every pixel accept
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int r = 0; r < K_DIM; r++)
                for (int c = 0; c < K_DIM - 1; c++)
                    win_q[r][c] <= tap[r][c+1];
            for (int r = 0; r < K_DIM - 2; r++)
                lb_q[r][col_q] <= lb_q[r+1][col_q];
            lb_q[K_DIM-2][col_q] <= pix_i;
        end
    end

    // Coefficients and ReLU mode are frozen at the first pixel of a frame
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            weights_q <= '0;
            relu_q    <= 1'b0;
        end else if (accept && (state_q != RUN)) begin
            weights_q <= weights_i;
            relu_q    <= relu_i;
        end
    end

    // Per-channel MAC, arithmetic shift, optional ReLU and saturation
    for (genvar gi = 0; gi < N_KERNELS; gi++) begin : g_ch
        logic signed [ACC_W-1:0]  acc;
        logic signed [ACC_W-1:0]  shifted;
        logic signed [ACC_W-1:0]  p_ext;
        logic signed [ACC_W-1:0]  w_ext;
        logic [W_WIDTH-1:0]       w_raw;
        logic [OUT_WIDTH-1:0]     res;

        always_comb begin
            acc   = '0;
            p_ext = '0;
            w_ext = '0;
            w_raw = '0;
            for (int r = 0; r < K_DIM; r++) begin
                for (int c = 0; c < K_DIM; c++) begin
                    w_raw = weights_q[(gi*KK + r*K_DIM + c)*W_WIDTH +: W_WIDTH];
                    p_ext = {{(ACC_W-PIX_WIDTH){1'b0}}, tap[r][c]};
                    w_ext = {{(ACC_W-W_WIDTH){w_raw[W_WIDTH-1]}}, w_raw};
                    acc   = acc + p_ext * w_ext;
                end
            end
            shifted = acc >>> SHIFT;
            if (relu_q && shifted[ACC_W-1])
                shifted = '0;
            if (shifted > SAT_MAX)
                res = OUT_MAX;
            else if (shifted < SAT_MIN)
                res = OUT_MIN;
            else
                res = shifted[OUT_WIDTH-1:0];
        end

        assign mac_out[gi*OUT_WIDTH +: OUT_WIDTH] = res;
    end

    // Single-stage output register with hold under backpressure
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (clear_i) begin
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mac_out;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: two builds (STRIDE=1/SHIFT=0 and STRIDE=2/SHIFT=4)
// driven frame by frame, outputs compared against a plain-arithmetic
// convolution of the same image.
module tb_conv2d_stream;

    localparam int IM = 28;
    localparam int K  = 3;
    localparam int NK = 4;
    localparam int WW = 12;
    localparam int WB = NK * K * K * WW;
    localparam int NPIX = IM * IM;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic          clear      [2];
    logic [WB-1:0] weights    [2];
    logic          relu       [2];
    logic [7:0]    pix        [2];
    logic          pix_valid  [2];
    logic          pix_ready  [2];
    logic [31:0]   out_data   [2];
    logic          out_valid  [2];
    logic          out_ready  [2];
    logic          busy       [2];
    logic          all_read   [2];
    logic          frame_done [2];

    int          img [IM][IM];
    int          wt  [NK][K][K];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    conv2d_stream #(.STRIDE(1), .SHIFT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear[0]), .weights_i(weights[0]),
        .relu_i(relu[0]), .pix_i(pix[0]), .pix_valid_i(pix_valid[0]),
        .pix_ready_o(pix_ready[0]), .out_data_o(out_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .busy_o(busy[0]),
        .all_read_o(all_read[0]), .frame_done_o(frame_done[0])
    );

    conv2d_stream #(.STRIDE(2), .SHIFT(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear[1]), .weights_i(weights[1]),
        .relu_i(relu[1]), .pix_i(pix[1]), .pix_valid_i(pix_valid[1]),
        .pix_ready_o(pix_ready[1]), .out_data_o(out_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .busy_o(busy[1]),
        .all_read_o(all_read[1]), .frame_done_o(frame_done[1])
    );

    // ---------------- stimulus helpers and reference model ----------------
    function automatic logic [WB-1:0] pack_weights();
        logic [WB-1:0] v = '0;
        for (int k = 0; k < NK; k++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    v[(k*K*K + r*K + c)*WW +: WW] = 12'(wt[k][r][c]);
        return v;
    endfunction

    // mode 0: ramp, 1: constant val, 2: random 0..val
    task automatic fill_img(input int mode, input int val);
        for (int r = 0; r < IM; r++)
            for (int c = 0; c < IM; c++)
                img[r][c] = (mode == 0) ? (r*IM + c) % 128 :
                            (mode == 1) ? val : int'($urandom_range(val));
    endtask

    // mode 0: center tap = val, 1: all taps = val, 2: random in [-val, val]
    task automatic fill_wt(input int mode, input int val);
        for (int k = 0; k < NK; k++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    wt[k][r][c] = (mode == 0) ? ((r == 1 && c == 1) ? val : 0) :
                                  (mode == 1) ? val :
                                  int'($urandom_range(2*val)) - val;
    endtask

    // Direct convolution: every window position, floor division by 2^shift
    task automatic build_expected(input int stride, input int shift, input bit rl);
        int n, acc, v, dv;
        logic [31:0] word;
        exp_q.delete();
        n  = (IM - K) / stride + 1;
        dv = 1 << shift;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                word = '0;
                for (int k = 0; k < NK; k++) begin
                    acc = 0;
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++)
                            acc += img[i*stride+kr][j*stride+kc] * wt[k][kr][kc];
                    v = (acc >= 0) ? acc / dv : -((-acc + dv - 1) / dv);
                    if (rl && v < 0) v = 0;
                    if (v > 127) v = 127;
                    if (v < -128) v = -128;
                    word[k*8 +: 8] = 8'(v);
                end
                exp_q.push_back(word);
            end
        end
    endtask

    // Drive one full frame into DUT d and check every output handshake
    task automatic run_frame(input int d, input bit rl, input int rdy_pct, input string name);
        int pidx = 0, cyc = 0, n_out = 0, n_ar = 0, n_fd = 0, n_exp;
        bit done = 0, stalled = 0, acc_now;
        logic [31:0] held = '0, e;
        build_expected((d == 0) ? 1 : 2, (d == 0) ? 0 : 4, rl);
        n_exp = exp_q.size();
        while (!done && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            // Correct coefficients only until the first accept; afterwards
            // the bus carries garbage the DUT must ignore.
            weights[d]   = (pidx == 0) ? pack_weights() : ~pack_weights();
            relu[d]      = (pidx == 0) ? rl : !rl;
            pix_valid[d] = (pidx < NPIX);
            pix[d]       = 8'h00;
            if (pidx < NPIX) pix[d] = 8'(img[pidx / IM][pidx % IM]);
            out_ready[d] = ($urandom_range(99) < rdy_pct);
            #1;
            acc_now = pix_valid[d] && pix_ready[d];
            total++;
            if (pix_ready[d] !== (!out_valid[d] || out_ready[d])) begin
                bad++;
                $display("FAIL %s ready cyc=%0d got=%b want=%b", name, cyc,
                         pix_ready[d], !out_valid[d] || out_ready[d]);
            end
            if (stalled) begin
                total++;
                if (out_valid[d] !== 1'b1 || out_data[d] !== held) begin
                    bad++;
                    $display("FAIL %s hold cyc=%0d got=%b/%h want=1/%h", name, cyc,
                             out_valid[d], out_data[d], held);
                end
            end
            if (out_valid[d] && out_ready[d]) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra output #%0d got=%h want=none", name, n_out, out_data[d]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data[d] !== e) begin
                        bad++;
                        $display("FAIL %s data #%0d got=%h want=%h", name, n_out, out_data[d], e);
                    end
                end
                n_out++;
            end
            total++;
            if (all_read[d] !== (acc_now && pidx == NPIX - 1)) begin
                bad++;
                $display("FAIL %s all_read cyc=%0d got=%b want=%b", name, cyc,
                         all_read[d], acc_now && pidx == NPIX - 1);
            end
            stalled = out_valid[d] && !out_ready[d];
            held    = out_data[d];
            if (all_read[d]) n_ar++;
            if (frame_done[d]) begin n_fd++; done = 1; end
            if (acc_now) pidx++;
        end
        @(negedge clk);
        pix_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        #1;
        total++;
        if (!done) begin bad++; $display("FAIL %s timeout got=no_frame_done want=frame_done", name); end
        total++;
        if (n_out != n_exp) begin bad++; $display("FAIL %s count got=%0d want=%0d", name, n_out, n_exp); end
        total++;
        if (n_ar != 1) begin bad++; $display("FAIL %s all_read_pulses got=%0d want=1", name, n_ar); end
        total++;
        if (n_fd != 1) begin bad++; $display("FAIL %s frame_done_pulses got=%0d want=1", name, n_fd); end
        total++;
        if (busy[d] !== 1'b0 || out_valid[d] !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after got=busy%b/valid%b want=0/0", name, busy[d], out_valid[d]);
        end
        $display("frame %s dut%0d: outputs=%0d expected=%0d cycles=%0d", name, d, n_out, n_exp, cyc);
    endtask

    // Push n pixels of the current image with no backpressure (partial frame)
    task automatic feed_pixels(input int d, input int n, input string name);
        int pidx = 0, cyc = 0, n_fd = 0;
        weights[d] = pack_weights();
        relu[d]    = 1'b0;
        while (pidx < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            pix_valid[d] = 1'b1;
            pix[d]       = 8'(img[pidx / IM][pidx % IM]);
            out_ready[d] = 1'b1;
            #1;
            if (frame_done[d]) n_fd++;
            if (pix_valid[d] && pix_ready[d]) pidx++;
        end
        @(negedge clk);
        pix_valid[d] = 1'b0;
        #1;
        total++;
        if (pidx != n || n_fd != 0 || busy[d] !== 1'b1) begin
            bad++;
            $display("FAIL %s partial got=pix%0d/done%0d/busy%b want=pix%0d/done0/busy1",
                     name, pidx, n_fd, busy[d], n);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (pix_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || out_data[d] !== 32'h0 ||
                busy[d] !== 1'b0 || all_read[d] !== 1'b0 || frame_done[d] !== 1'b0) begin
                bad++;
                $display("FAIL %s dut%0d got=rdy%b val%b data%h busy%b ar%b fd%b want=all_zero",
                         name, d, pix_ready[d], out_valid[d], out_data[d], busy[d],
                         all_read[d], frame_done[d]);
            end
        end
    endtask

    // ------------------------------- tests ---------------------------------
    task automatic test_reset();
        #1 rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            pix_valid[d] = 1'b1;
            out_ready[d] = 1'b0;
        end
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_held");
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pix_valid[d] = 1'b0;
            out_ready[d] = 1'b1;
        end
    endtask

    task automatic test_identity();
        fill_img(0, 0);
        fill_wt(0, 1);
        run_frame(0, 1'b0, 100, "identity");
    endtask

    task automatic test_saturate();
        fill_img(1, 255);
        fill_wt(1, 1);
        run_frame(1, 1'b0, 100, "sat_pos");
    endtask

    task automatic test_negative_relu();
        fill_img(1, 255);
        fill_wt(1, -1);
        run_frame(1, 1'b0, 100, "sat_neg");
        run_frame(1, 1'b1, 100, "relu_neg");
    endtask

    task automatic test_backpressure();
        fill_img(2, 15);
        fill_wt(2, 2);
        run_frame(0, 1'b0, 50, "bp_random");
        fill_img(2, 255);
        fill_wt(2, 8);
        run_frame(1, 1'b1, 50, "bp_random_relu");
    endtask

    task automatic test_stride2();
        fill_img(0, 0);
        fill_wt(0, 16);
        run_frame(1, 1'b0, 70, "stride2_identity");
    endtask

    task automatic test_abort_reset();
        fill_img(0, 0);
        fill_wt(0, 1);
        feed_pixels(0, 300, "rst_abort");
        rst          = 1'b1;
        pix_valid[0] = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst_mid_held");
        rst          = 1'b0;
        pix_valid[0] = 1'b0;
        run_frame(0, 1'b0, 100, "after_reset");
    endtask

    task automatic test_abort_clear();
        fill_img(0, 0);
        fill_wt(0, 1);
        feed_pixels(0, 300, "clr_abort");
        clear[0]     = 1'b1;
        pix_valid[0] = 1'b1;
        #1;
        total++;
        if (frame_done[0] !== 1'b0 || all_read[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_pulse got=fd%b/ar%b want=0/0", frame_done[0], all_read[0]);
        end
        @(negedge clk);
        clear[0]     = 1'b0;
        pix_valid[0] = 1'b0;
        #1;
        total++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_idle got=valid%b/busy%b want=0/0", out_valid[0], busy[0]);
        end
        run_frame(0, 1'b0, 60, "after_clear");
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            clear[d]     = 1'b0;
            weights[d]   = '0;
            relu[d]      = 1'b0;
            pix[d]       = 8'h00;
            pix_valid[d] = 1'b0;
            out_ready[d] = 1'b1;
        end
        test_reset();
        test_identity();
        test_saturate();
        test_negative_relu();
        test_backpressure();
        test_stride2();
        test_abort_reset();
        test_abort_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
